// File: rtl/pattern_det_pkg.sv
// Shared encodings and reset configuration for the programmable pattern detector.
package pattern_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_LEN     = 4;

endpackage

// File: rtl/pat_match_shreg.sv
// Serial history shift register with fill tracking and a length-masked comparator.
// o_hit is combinational and describes the bit currently on i_din.
module pat_match_shreg
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shift,
    input  logic             i_din,
    input  logic             i_clr,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_next;
    logic [PAT_W-1:0] w_mask;
    logic             w_filled;

    assign w_next   = {r_hist[PAT_W-2:0], i_din};
    // The incoming bit counts toward the fill, hence the +1.
    assign w_filled = ({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, i_len};

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
    end

    assign o_hit = w_filled && ((w_next & w_mask) == (i_pattern & w_mask));

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_next;
            if (r_fill != LEN_W'(PAT_W)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run controller for the serial pattern detector: config registers, window FSM,
// bit/match counters with saturation and sticky overflow.
module pattern_detect_ctrl
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3,
    parameter int WIN_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             din_valid,
    input  logic             din,
    output logic             din_ready,
    output logic             busy,
    output logic             done,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    state_t           r_state;
    state_t           w_next_state;

    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_pulse;

    logic [LEN_W-1:0] w_len_eff;
    logic             w_start_go;
    logic             w_accept;
    logic             w_last;
    logic             w_hit;
    logic             w_clr;

    assign w_len_eff  = (r_len == '0)                 ? LEN_W'(1)     :
                        (r_len > LEN_W'(PAT_W))       ? LEN_W'(PAT_W) : r_len;
    assign w_start_go = start && (r_state == IDLE || r_state == DONE);
    assign w_accept   = din_valid && (r_state == RUN);
    assign w_last     = w_accept && ((r_bit_cnt + WIN_W'(1)) == r_win_len);
    // Non-overlap mode wipes history on the matching bit itself.
    assign w_clr      = w_start_go || (w_accept && w_hit && !r_overlap);

    pat_match_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .i_shift   (w_accept),
        .i_din     (din),
        .i_clr     (w_clr),
        .i_pattern (r_pattern),
        .i_len     (w_len_eff),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == RUN);
        din_ready = (r_state == RUN);
        done      = (r_state == DONE);
    end

    assign match_pulse = r_pulse;
    assign match_count = r_count;
    assign overflow    = r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= PAT_W'(DEF_PATTERN);
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= 1'b1;
        end else if (cfg_we && r_state != RUN) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_len  <= '0;
            r_bit_cnt  <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= w_accept && w_hit;
            if (w_start_go) begin
                r_win_len  <= win_len;
                r_bit_cnt  <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + WIN_W'(1);
                if (w_hit) begin
                    if (r_count == '1) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: two instances (8-bit and 2-bit match counter) share
// stimulus; a queue-based reference model predicts pulses, counts and overflow.
module tb_pattern_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_pattern = '0;
    logic [2:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] win_len = '0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;

    logic        rdy_a, busy_a, done_a, mp_a, ovf_a;
    logic [7:0]  cnt_a;
    logic        rdy_b, busy_b, done_b, mp_b, ovf_b;
    logic [1:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // model results
    bit m_pulse[$];
    int m_c2[$];
    bit m_o2[$];
    int m_cnt8;
    bit m_ovf8;

    // observed per accepted bit
    bit o_p8[$];
    bit o_p2[$];
    int o_c2[$];
    bit o_o2[$];
    bit o_stray;
    bit o_rdy_low;

    always #5 clk = ~clk;

    pattern_detect_ctrl #(.CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
        .win_len(win_len), .din_valid(din_valid), .din(din), .din_ready(rdy_a),
        .busy(busy_a), .done(done_a), .match_pulse(mp_a), .match_count(cnt_a),
        .overflow(ovf_a)
    );

    pattern_detect_ctrl #(.CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .abort(abort),
        .win_len(win_len), .din_valid(din_valid), .din(din), .din_ready(rdy_b),
        .busy(busy_b), .done(done_b), .match_pulse(mp_b), .match_count(cnt_b),
        .overflow(ovf_b)
    );

    // Reference: keep the bits received since the last clear; a match is the
    // newest len bits read backwards equalling pattern[0..len-1].
    function automatic void model_window(input logic [3:0] pat, input int lc,
                                         input bit ovl, input int n, input logic [63:0] bits);
        bit h[$];
        int len;
        int c2;
        bit o2;
        bit hit;
        len = (lc == 0) ? 1 : ((lc > 4) ? 4 : lc);
        c2 = 0; o2 = 0; m_cnt8 = 0; m_ovf8 = 0;
        m_pulse.delete(); m_c2.delete(); m_o2.delete();
        for (int i = 0; i < n; i++) begin
            h.push_back(bits[i]);
            hit = (h.size() >= len);
            for (int k = 0; k < len; k++) begin
                if (hit && h[h.size()-1-k] != pat[k]) hit = 0;
            end
            if (hit) begin
                if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
                if (c2 == 3) o2 = 1; else c2++;
                if (!ovl) h.delete();
            end
            m_pulse.push_back(hit);
            m_c2.push_back(c2);
            m_o2.push_back(o2);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] p, input logic [2:0] l, input bit o);
        cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        tick();
        cfg_we = 0;
    endtask

    task automatic do_start(input int w);
        start = 1; win_len = 16'(w);
        tick();
        start = 0;
    endtask

    task automatic do_abort();
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic idle_cycle();
        din_valid = 0; din = 1'($urandom);
        tick();
        if (mp_a || mp_b) o_stray = 1;
    endtask

    task automatic drive_stream(input int n, input logic [63:0] bits, input int pct,
                                input int stall_at, input int stall_len);
        o_p8.delete(); o_p2.delete(); o_c2.delete(); o_o2.delete();
        o_stray = 0; o_rdy_low = 0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) repeat (stall_len) idle_cycle();
            for (int s = 0; s < 3 && int'($urandom_range(99)) < pct; s++) idle_cycle();
            if (!rdy_a || !rdy_b) o_rdy_low = 1;
            din_valid = 1; din = bits[i];
            tick();
            o_p8.push_back(mp_a); o_p2.push_back(mp_b);
            o_c2.push_back(int'(cnt_b)); o_o2.push_back(ovf_b);
            din_valid = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) tick();
        n_tests++;
        if ({rdy_a, busy_a, done_a, mp_a, cnt_a, ovf_a, rdy_b, busy_b, done_b, mp_b, cnt_b, ovf_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs a=%b/%b/%b/%b/%0d/%b b=%b/%b/%b/%b/%0d/%b want all 0",
                     rdy_a, busy_a, done_a, mp_a, cnt_a, ovf_a, rdy_b, busy_b, done_b, mp_b, cnt_b, ovf_b);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_overlap_default();
        // no cfg write: relies on the reset pattern 1011 / len 4 / overlap
        do_start(7);
        drive_stream(7, 64'b1101101, 0, -1, 0);
        model_window(4'b1011, 4, 1, 7, 64'b1101101);
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (o_p8[i] !== m_pulse[i]) begin
                n_fail++;
                $display("FAIL ovl_pulse bit%0d got %b want %b", i + 1, o_p8[i], m_pulse[i]);
            end
        end
        n_tests++;
        if (cnt_a !== 8'd2 || m_cnt8 != 2) begin
            n_fail++;
            $display("FAIL ovl_count got %0d want 2", cnt_a);
        end
        n_tests++;
        if (done_a !== 1'b1 || rdy_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovl_done done=%b rdy=%b busy=%b want 1/0/0", done_a, rdy_a, busy_a);
        end
    endtask

    task automatic test_nonoverlap();
        do_cfg(4'b1011, 3'd4, 0);
        do_start(7);
        drive_stream(7, 64'b1101101, 0, -1, 0);
        n_tests++;
        if (cnt_a !== 8'd1 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL nonovl_count got %0d done=%b want 1 done=1", cnt_a, done_a);
        end
    endtask

    task automatic test_len2_stall();
        do_cfg(4'b1101, 3'd2, 1);
        do_start(6);
        drive_stream(6, 64'b101010, 0, -1, 0);
        n_tests++;
        if (cnt_a !== 8'd3 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL len2_count got %0d done=%b want 3 done=1", cnt_a, done_a);
        end
        do_start(6);
        drive_stream(6, 64'b101010, 0, 3, 5);
        n_tests++;
        if (cnt_a !== 8'd3 || done_a !== 1'b1 || o_stray || o_rdy_low) begin
            n_fail++;
            $display("FAIL len2_stall count=%0d done=%b stray=%b rdy_low=%b want 3/1/0/0",
                     cnt_a, done_a, o_stray, o_rdy_low);
        end
    endtask

    task automatic test_saturate();
        do_cfg(4'b0001, 3'd1, 1);
        do_start(5);
        drive_stream(5, 64'b11111, 0, -1, 0);
        n_tests++;
        if (o_o2[2] !== 1'b0 || o_o2[3] !== 1'b1 || o_c2[2] != 3) begin
            n_fail++;
            $display("FAIL sat_step ovf@3=%b ovf@4=%b cnt@3=%0d want 0/1/3", o_o2[2], o_o2[3], o_c2[2]);
        end
        n_tests++;
        if (cnt_b !== 2'd3 || ovf_b !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_b count=%0d ovf=%b want 3/1", cnt_b, ovf_b);
        end
        n_tests++;
        if (cnt_a !== 8'd5 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_a count=%0d ovf=%b want 5/0", cnt_a, ovf_a);
        end
    endtask

    task automatic test_abort_cfg();
        do_cfg(4'b1011, 3'd4, 1);
        do_start(10);
        drive_stream(3, 64'b101, 0, -1, 0);
        do_abort();
        n_tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_idle busy=%b done=%b count=%0d want 0/0/0", busy_a, done_a, cnt_a);
        end
        repeat (3) tick();
        n_tests++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nodone done=%b want 0", done_a);
        end
        // config write while busy must not take effect
        do_start(4);
        do_cfg(4'b0001, 3'd1, 1);
        do_abort();
        do_start(4);
        drive_stream(4, 64'b1101, 0, -1, 0);
        model_window(4'b1011, 4, 1, 4, 64'b1101);
        n_tests++;
        if (cnt_a !== 8'(m_cnt8) || cnt_a !== 8'd1 || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_busy count=%0d done=%b want 1 done=1", cnt_a, done_a);
        end
    endtask

    task automatic test_zero_win();
        do_start(0);
        n_tests++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_win done=%b busy=%b count=%0d want 1/0/0", done_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_reset_midwin();
        do_cfg(4'b0001, 3'd1, 0);
        do_start(8);
        drive_stream(2, 64'b11, 0, -1, 0);
        reset = 1; din_valid = 1; din = 1;
        tick();
        din_valid = 0;
        n_tests++;
        if ({rdy_a, busy_a, done_a, mp_a, cnt_a, ovf_a, mp_b, cnt_b} !== '0) begin
            n_fail++;
            $display("FAIL midwin_reset rdy=%b busy=%b done=%b pulse=%b count=%0d ovf=%b want all 0",
                     rdy_a, busy_a, done_a, mp_a, cnt_a, ovf_a);
        end
        reset = 0;
        tick();
        do_start(4);
        drive_stream(4, 64'b1101, 0, -1, 0);
        n_tests++;
        if (cnt_a !== 8'd1 || done_a !== 1'b1 || o_p8[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_default count=%0d done=%b pulse4=%b want 1/1/1", cnt_a, done_a, o_p8[3]);
        end
    endtask

    task automatic test_random();
        logic [3:0]  pat;
        int          lc;
        bit          ovl;
        int          n;
        logic [63:0] bits;
        for (int w = 0; w < 10; w++) begin
            pat  = 4'($urandom);
            lc   = int'($urandom_range(7));
            ovl  = 1'($urandom);
            n    = int'($urandom_range(40, 1));
            bits = {$urandom, $urandom};
            do_cfg(pat, 3'(lc), ovl);
            do_start(n);
            drive_stream(n, bits, 30, -1, 0);
            model_window(pat, lc, ovl, n, bits);
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (o_p8[i] !== m_pulse[i] || o_p2[i] !== m_pulse[i] ||
                    o_c2[i] != m_c2[i] || o_o2[i] !== m_o2[i]) begin
                    n_fail++;
                    $display("FAIL rand_bit w%0d b%0d pulse=%b/%b cnt2=%0d ovf2=%b want %b/%0d/%b",
                             w, i, o_p8[i], o_p2[i], o_c2[i], o_o2[i], m_pulse[i], m_c2[i], m_o2[i]);
                end
            end
            n_tests++;
            if (cnt_a !== 8'(m_cnt8) || ovf_a !== m_ovf8 || done_a !== 1'b1 ||
                o_stray || o_rdy_low) begin
                n_fail++;
                $display("FAIL rand_end w%0d count=%0d ovf=%b done=%b stray=%b rdy_low=%b want %0d/%b/1/0/0",
                         w, cnt_a, ovf_a, done_a, o_stray, o_rdy_low, m_cnt8, m_ovf8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_default();
        test_nonoverlap();
        test_len2_stall();
        test_saturate();
        test_abort_cfg();
        test_zero_win();
        test_reset_midwin();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
- Run controller for a programmable serial pattern detector (generalises the fixed 1011 detector).
- Holds the pattern configuration and arms the detector for a window of N accepted input bits.
- Counts matches in overlap or non-overlap mode and reports completion with a busy/done handshake.
- Sits between the serial bit source and the status/control logic that reads match counts.

Parameters:
- PAT_W, 4, maximum pattern length in bits.
- LEN_W, 3, width of cfg_len; must hold the value PAT_W.
- WIN_W, 16, width of the window-length field and the bit counter.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cfg_we  input  1  latch cfg_pattern/cfg_len/cfg_overlap; honoured only when busy=0
- cfg_pattern  input  PAT_W  pattern; the bit received last is compared against bit 0
- cfg_len  input  LEN_W  active pattern length
- cfg_overlap  input  1  1 = overlapping matches counted, 0 = history cleared after each match
- start  input  1  begin a window; honoured in IDLE and DONE
- abort  input  1  terminate the window; honoured in RUN
- win_len  input  WIN_W  number of bits to accept; sampled when start is honoured
- din_valid  input  1  serial bit valid
- din  input  1  serial bit
- din_ready  output  1  high only in RUN; a bit is accepted when din_valid & din_ready
- busy  output  1  high in RUN
- done  output  1  high in DONE, held until start or reset
- match_pulse  output  1  one-cycle pulse per match
- match_count  output  CNT_W  matches counted in the current/last window
- overflow  output  1  sticky; set when a match occurs with match_count at all-ones

Behaviour:
- Single clock domain; reset is synchronous and active-high, and the clock and reset ports are named clk and reset.
- Reset state: state=IDLE, pattern=4'b1011, len=4, overlap=1.
- All outputs are 0 after reset; history, fill counter and bit counter are 0.
- Effective length: cfg_len=0 is treated as 1; cfg_len>PAT_W is treated as PAT_W.
- cfg_we is ignored while busy; the configuration is stable for the whole window.

States (registered, Moore-style outputs):
- IDLE: start -> RUN. The same cycle clears history, fill, bit_cnt, match_count and overflow, and latches win_len. If start arrives with win_len=0, go directly to DONE with count 0.
- RUN: on each accepted bit:
  - history <= {history[PAT_W-2:0], din}
  - fill <= min(fill+1, PAT_W)
  - bit_cnt <= bit_cnt+1
  - Match: (fill+1) >= len, and the low len bits of the new history equal the low len bits of the pattern.
  - On a match, match_pulse is high in the next cycle and match_count increments in that same next cycle, saturating at 2^CNT_W-1. If the count is already saturated, overflow is set instead.
  - Non-overlap mode: a match also zeroes history and fill, so the next match needs len fresh bits.
  - After the bit that makes bit_cnt equal win_len is accepted, go to DONE on the next cycle. din_ready drops in that cycle; that final bit's match_pulse is coincident with done rising.
  - Cycles without din_valid leave all state unchanged.
- abort in RUN -> IDLE on the next cycle. match_count is retained, done stays 0, and a match from the final accepted bit is still counted.
- abort in IDLE or DONE is ignored.
- DONE: done=1, and match_count and overflow are frozen. start begins a new window (same clearing as in IDLE); cfg_we is accepted.
- start and abort together in RUN: abort wins and start is ignored.
- reset asserted mid-window returns to the reset state on the next edge, with no match_pulse.

Decomposition:
- Shared package pattern_det_pkg holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - default pattern 4'b1011 and default length 4
- One sub-module, pat_match_shreg, contains the shift register, fill counter and masked comparator. It outputs a combinational hit for the incoming bit and takes a clear input for non-overlap mode and start.
- The controller holds the FSM, window counter, match counter, overflow and config registers.

Test Plan:
- Reset, then start with win_len=7, overlap=1, pattern 1011/len 4; stream 1,0,1,1,0,1,1 -> match_pulse after bits 4 and 7, match_count=2, done one cycle after bit 7, din_ready=0 in DONE.
- Same stream with overlap=0 -> match_count=1 at done.
- Set cfg_len=2, pattern xx01, win_len=6; stream 0,1,0,1,0,1 -> match_count=3. Hold din_valid low for 5 cycles mid-stream -> same result, bit_cnt unaffected.
- CNT_W=2, pattern 1/len 1, win_len=5, all ones -> match_count saturates at 3 and overflow=1 after the 4th match.
- Abort after 3 bits of 1,0,1,1 -> IDLE with count 0 and done never asserted. cfg_we with busy=1 ignored, verified on the next window. start with win_len=0 -> done next cycle, count 0.
- Assert reset mid-window after 2 bits -> all outputs 0 next cycle and state IDLE; a subsequent start runs cleanly with the default pattern 1011.
